// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the multi-port register file: write ports, read ports, reservation, status.
// Port k of a packed field occupies bits [k*W +: W].
interface regfile_mp_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);
  logic                     init_done;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;

  modport master (
    input  init_done, rd_data, rd_busy,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, rsv_en, rsv_addr
  );

  modport slave (
    output init_done, rd_data, rd_busy,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, rsv_en, rsv_addr
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass, pending-write scoreboard
// and a post-reset zeroing sweep. Register 0 reads as zero and ignores writes/reservations.
module regfile_mp_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input logic                  clk,
  input logic                  rst,
  regfile_mp_sb_if.slave       bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {StInit, StRun} state_e;

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_cnt, w_cnt_d;
  logic [DEPTH-1:0]  r_pending, w_pending_d;
  logic [DATA_W-1:0] r_regs [DEPTH];

  logic              w_run;
  logic [ADDR_W-1:0] w_wa [NUM_WR];
  logic [DATA_W-1:0] w_wd [NUM_WR];
  logic              w_wv [NUM_WR];

  assign w_run         = (r_state == StRun);
  assign bus.init_done = w_run;

  // Effective write strobes: ignored during the sweep and for register 0.
  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      w_wa[k] = bus.wr_addr[k*ADDR_W +: ADDR_W];
      w_wd[k] = bus.wr_data[k*DATA_W +: DATA_W];
      w_wv[k] = w_run & bus.wr_en[k] & (w_wa[k] != '0);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StInit: begin
        w_cnt_d = r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(DEPTH - 1)) w_state_d = StRun;
      end
      StRun: ;
      default: w_state_d = StInit;
    endcase
  end

  // A same-cycle reservation overrides a completing write: a new producer is in flight.
  always_comb begin
    w_pending_d = r_pending;
    if (w_run) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (w_wv[k]) w_pending_d[w_wa[k]] = 1'b0;
      end
      if (bus.rsv_en && (bus.rsv_addr != '0)) w_pending_d[bus.rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StInit;
      r_cnt     <= ADDR_W'(1);
      r_pending <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_pending <= w_pending_d;
    end
  end

  // Array has no reset; the sweep zeroes it. Ascending loop lets the highest port win.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == StInit) begin
        r_regs[r_cnt] <= '0;
      end else begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (w_wv[k]) r_regs[w_wa[k]] <= w_wd[k];
        end
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              hit;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra  = bus.rd_addr[i*ADDR_W +: ADDR_W];
      rd  = '0;
      hit = 1'b0;
      if (w_run && bus.rd_en[i] && (ra != '0)) begin
        rd = r_regs[ra];
        for (int k = 0; k < NUM_WR; k++) begin
          if (w_wv[k] && (w_wa[k] == ra)) begin
            rd  = w_wd[k];
            hit = 1'b1;
          end
        end
        bus.rd_busy[i] = r_pending[ra] & ~hit;
      end
      bus.rd_data[i*DATA_W +: DATA_W] = rd;
    end
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port general-purpose register file for the CPU datapath. It extends the two-read/one-write file with a configurable number of read and write ports and with write-to-read bypass on every port. It adds a per-register pending-write scoreboard that the decode stage uses for hazard stalls, and a post-reset init sweep that zeroes the whole array.

Parameters:
DATA_W  32  register width in bits
ADDR_W  5  register address width; DEPTH = 2**ADDR_W registers
NUM_RD  2  number of read ports
NUM_WR  2  number of write ports; higher port index has higher priority

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
init_done  out  1  high once the zeroing sweep has finished
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
wr_data  in  NUM_WR*DATA_W  write data; packed the same way as wr_addr
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  read addresses; packed the same way
rd_data  out  NUM_RD*DATA_W  read data, combinational
rd_busy  out  NUM_RD  read operand has an outstanding producer (stall request)
rsv_en  in  1  reserve a destination register (instruction issue)
rsv_addr  in  ADDR_W  register to mark as pending

Behaviour:
- Register 0 is hardwired to zero:
  - writes to it are dropped;
  - reserving it is dropped;
  - reading it returns 0 and rd_busy = 0.
- Two-state FSM, INIT and RUN.
- Reset, taken on any clock edge with rst = 1 and regardless of the current state (including mid-sweep):
  - state goes to INIT, sweep counter = 1, all pending bits cleared, init_done = 0;
  - the register array is not touched in the reset cycle itself.
- INIT:
  - each cycle writes 0 into regs[cnt], then cnt increments;
  - when cnt = DEPTH-1 that register is written and the state moves to RUN on the same edge;
  - init_done rises DEPTH-1 cycles after the first non-reset edge (31 for the defaults).
- Behaviour while in INIT:
  - wr_en and rsv_en are ignored;
  - rd_data = 0 and rd_busy = 0 on all ports.
- RUN, writes:
  - each wr_en[k] with wr_addr[k] != 0 writes wr_data[k] on the clock edge;
  - if several ports hit the same address in one cycle, the highest k wins.
- RUN, reads, port i, combinational priority:
  1. rd_en[i] = 0 gives 0;
  2. rd_addr[i] = 0 gives 0;
  3. a same-cycle write hit gives that wr_data, highest k winning;
  4. otherwise regs[rd_addr[i]].
- RUN, scoreboard:
  - pending[a] is set on an edge with rsv_en = 1 and rsv_addr = a (a != 0);
  - it is cleared on an edge where any write port writes a;
  - if a reservation and a write target the same register in the same cycle, the reservation wins and pending stays 1, because a new producer has been issued;
  - reserving an already-pending register leaves it at 1.
- rd_busy[i] = rd_en[i] & (rd_addr[i] != 0) & pending[rd_addr[i]] & no same-cycle write hit.
  - A bypassed operand is therefore never reported busy.
  - A same-cycle reservation does not affect rd_busy until the next cycle.
- Latency:
  - write to array: visible via the array path one cycle later, and the same cycle via bypass;
  - reserve to rd_busy: one cycle.
- No X on any output after reset; the array is undefined only until the sweep has covered each entry.

Test Plan:
- Reset then hold rst = 0 (default params) -> init_done = 0 for 31 cycles, then 1. Reading regs 1..31 afterwards returns 0x00000000.
- Assert rst at sweep cycle 10 -> sweep restarts and init_done rises 31 cycles after rst drops. A write issued during INIT (addr 5, 0xDEADBEEF) is lost; reg 5 reads 0.
- In RUN, wr port0 addr 3 = 0x11111111 and port1 addr 3 = 0x22222222 in the same cycle -> a same-cycle read of 3 gives 0x22222222, and the next cycle the array gives 0x22222222.
- Write addr 0 = 0xFFFFFFFF, then read addr 0 -> 0 and rd_busy = 0. Read with rd_en = 0 at addr 3 -> 0.
- rsv addr 7, then next cycle read 7 -> rd_busy = 1. Next, write 7 = 0xA5A5A5A5 with a same-cycle read -> rd_busy = 0 and data 0xA5A5A5A5. The following cycle pending[7] = 0.
- Same cycle: rsv 9 and write 9 = 0x5 -> next cycle, reading 9 gives rd_busy = 1 and rd_data = 0x5.
